// File: rtl/uart_tx_framer.sv
// UART transmitter: one-entry holding register feeding an LSB-first serialiser.
// Define UART_TX_PARITY_EN to insert a parity bit between the data and stop bits.
module uart_tx_framer #(
    parameter int DATA_WIDTH     = 8,
    parameter int CLOCKS_PER_BIT = 16,
    parameter int STOP_BITS      = 1,
    parameter int PARITY_ODD     = 0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] DataIn,
    input  logic                  DataValid,
    output logic                  DataReady,
    output logic                  DataOut,
    output logic                  Busy
);

    localparam int BAUD_W = $clog2(CLOCKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  out_q, out_d;
    logic                  busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic                  par_q, par_d;
`endif

    logic accept;
    logic load;
    logic baud_wrap;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
`ifdef UART_TX_PARITY_EN
        par_d       = par_q;
`endif
        load        = 1'b0;
        accept      = DataValid && !hold_full_q;
        baud_wrap   = (baud_q == BAUD_LAST);

        if (accept) begin
            hold_d      = DataIn;
            hold_full_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (hold_full_q) begin
                    load    = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_wrap) state_d = S_DATA;
            end
            S_DATA: begin
                if (baud_wrap) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_wrap) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (baud_wrap) begin
                    if (bit_q == STOP_LAST) begin
                        // A queued word starts its frame with no idle cycle in between.
                        if (hold_full_q) begin
                            load    = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // load and accept never coincide: accept needs the holding register empty.
        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_d       = (^hold_q) ^ (PARITY_ODD != 0);
`endif
        end

        if (state_d != state_q || load) begin
            baud_d = '0;
            bit_d  = '0;
        end else if (state_q != S_IDLE) begin
            baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        end

        case (state_d)
            S_START:  out_d = 1'b0;
            S_DATA:   out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: out_d = par_d;
`endif
            default:  out_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE) || hold_full_d;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            baud_q      <= '0;
            bit_q       <= '0;
            out_q       <= 1'b1;
            busy_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            out_q       <= out_d;
            busy_q      <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign DataReady = !hold_full_q;
    assign DataOut   = out_q;
    assign Busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: table-driven single frames plus
// back-to-back, short-frame and mid-frame reset sequences.
module tb_uart_tx_framer;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int CPB  = 4;
    localparam int F    = (10 + P) * CPB;
    localparam int CPB2 = 2;
    localparam int F2   = (8 + P) * CPB2;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] din   = '0;
    logic       dv    = 1'b0;
    logic       dr, dout, busy;
    logic [4:0] din2  = '0;
    logic       dv2   = 1'b0;
    logic       dr2, dout2, busy2;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] din;
        logic [9:0] frame;   // bit k = line level during serial bit k (start..stop)
        logic       par;     // even parity of din
    } vec_t;

    vec_t       vecs[5];
    logic [9:0] bb_fr[3];
    logic       bb_par[3];
    logic [8:0] fr2;

    always #5 Clock = ~Clock;

    uart_tx_framer #(.DATA_WIDTH(8), .CLOCKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut (
        .Clock(Clock), .Reset(Reset), .DataIn(din), .DataValid(dv),
        .DataReady(dr), .DataOut(dout), .Busy(busy)
    );

    uart_tx_framer #(.DATA_WIDTH(5), .CLOCKS_PER_BIT(CPB2), .STOP_BITS(2), .PARITY_ODD(1)) dut2 (
        .Clock(Clock), .Reset(Reset), .DataIn(din2), .DataValid(dv2),
        .DataReady(dr2), .DataOut(dout2), .Busy(busy2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input logic [9:0] fr, input logic par, input int k);
        if (P == 1 && k == 9) return par;
        if (k >= 9) return 1'b1;
        return fr[4'(k)];
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h55, 10'h2AA, 1'b0};
        vecs[1] = '{8'h07, 10'h20E, 1'b1};
        vecs[2] = '{8'h00, 10'h200, 1'b0};
        vecs[3] = '{8'hFF, 10'h3FE, 1'b0};
        vecs[4] = '{8'h80, 10'h300, 1'b1};
        bb_fr[0] = 10'h34A; bb_par[0] = 1'b0;   // 0xA5
        bb_fr[1] = 10'h278; bb_par[1] = 1'b0;   // 0x3C
        bb_fr[2] = 10'h386; bb_par[2] = 1'b0;   // 0xC3
`ifdef UART_TX_PARITY_EN
        fr2 = 9'h1BE;   // start, 11111, odd parity 0, stop, stop
`else
        fr2 = 9'h0FE;   // start, 11111, stop, stop
`endif

        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("reset_dout", dout, 1);
        check("reset_ready", dr, 1);
        check("reset_busy", busy, 0);
        check("reset_dout2", dout2, 1);
        check("reset_busy2", busy2, 0);
        Reset = 1'b1;
        repeat (2) @(negedge Clock);

        // isolated frames
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            check("vec_ready_before", dr, 1);
            dv  = 1'b1;
            din = vecs[i].din;
            @(posedge Clock);
            @(negedge Clock);
            dv = 1'b0;
            check("vec_busy_after_hs", busy, 1);
            check("vec_ready_after_hs", dr, 0);
            check("vec_idle_after_hs", dout, 1);
            for (int c = 0; c < F; c++) begin
                @(negedge Clock);
                check($sformatf("vec%0d_bit%0d", i, c / CPB), dout,
                      exp_bit(vecs[i].frame, vecs[i].par, c / CPB));
                if (c == 0) check("vec_ready_at_start", dr, 1);
                if (c == F - 1) check("vec_busy_last", busy, 1);
            end
            @(negedge Clock);
            check("vec_busy_end", busy, 0);
            check("vec_line_end", dout, 1);
        end

        // back-to-back: DataValid held, DataIn churning while not ready
        @(negedge Clock);
        dv  = 1'b1;
        din = 8'hA5;
        @(posedge Clock);
        for (int s = 1; s <= 3 * F + 2; s++) begin
            @(negedge Clock);
            if (s >= 2) begin
                int a;
                a = s - 1;
                if (a <= 3 * F) begin
                    check($sformatf("bb_line_%0d", a), dout,
                          exp_bit(bb_fr[(a - 1) / F], bb_par[(a - 1) / F], ((a - 1) % F) / CPB));
                    check($sformatf("bb_busy_%0d", a), busy, 1);
                end else begin
                    check("bb_line_idle", dout, 1);
                    check("bb_busy_idle", busy, 0);
                end
                check($sformatf("bb_ready_%0d", a), dr,
                      (a == 1 || a == F + 1 || a >= 2 * F + 1) ? 1 : 0);
            end
            if (s <= 2) begin
                din = 8'h3C;
            end else if (s <= F + 1) begin
                din = 8'h40 + 8'(s);
            end else if (s == F + 2) begin
                din = 8'hC3;
            end else begin
                dv = 1'b0;
            end
            @(posedge Clock);
        end
        dv = 1'b0;

        // short frame, two stop bits
        @(negedge Clock);
        dv2  = 1'b1;
        din2 = 5'h1F;
        @(posedge Clock);
        @(negedge Clock);
        dv2 = 1'b0;
        for (int c = 0; c < F2; c++) begin
            @(negedge Clock);
            check($sformatf("short_bit%0d", c / CPB2), dout2, fr2[4'(c / CPB2)]);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge Clock);
            check("short_no_restart", dout2, 1);
            check("short_busy_end", busy2, 0);
        end

        // reset in the middle of data bit 2 with a word queued
        @(negedge Clock);
        dv  = 1'b1;
        din = 8'h0B;
        @(posedge Clock);
        @(negedge Clock);
        din = 8'hF0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        dv = 1'b0;
        check("rst_queued", dr, 0);
        repeat (12) @(posedge Clock);
        #2;
        check("rst_pre_line", dout, 0);
        Reset = 1'b0;
        #1;
        check("rst_line", dout, 1);
        check("rst_ready", dr, 1);
        check("rst_busy", busy, 0);
        @(negedge Clock);
        Reset = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge Clock);
            check("rst_no_resume_line", dout, 1);
            check("rst_no_resume_busy", busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
